// File: rtl/sipo_window_reg.sv
// rtl/sipo_window_reg.sv - serial-in/parallel-out sliding window with word framer
// Optional registered pattern comparator enabled by defining SIPO_MATCH_EN.
module sipo_window_reg #(
  parameter int               WIDTH     = 4,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] PATTERN   = WIDTH'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [WIDTH-1:0] window,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             fill,
  output logic             match
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] next_window;
  logic             frame_done;

  always_comb begin
    next_window = window;
    if (MSB_FIRST) begin
      next_window = {window[WIDTH-2:0], data_in};
    end else begin
      next_window = {data_in, window[WIDTH-1:1]};
    end
  end

  assign frame_done = shift_en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      fill       <= 1'b0;
      cnt        <= '0;
    end else if (clear) begin
      window     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      fill       <= 1'b0;
      cnt        <= '0;
    end else begin
      word_valid <= 1'b0;
      if (shift_en) begin
        window <= next_window;
        // Explicit wrap so non-power-of-two widths frame correctly.
        if (frame_done) begin
          word       <= next_window;
          word_valid <= 1'b1;
          fill       <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef SIPO_MATCH_EN
  // Compared against post-shift state so match aligns with window and fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match <= 1'b0;
    end else if (clear) begin
      match <= 1'b0;
    end else if (shift_en) begin
      match <= (next_window == PATTERN) && (fill || frame_done);
    end
  end
`else
  assign match = 1'b0;
`endif

endmodule
